// File: rtl/fxp_pkg.sv
// Shared types and width helpers for the streaming fixed-point adder.
// Widths are derived at elaboration time from the operand and result formats.
package fxp_pkg;

  typedef enum logic {RND_TRUNC = 1'b0, RND_HALF_UP = 1'b1} round_e;

  function automatic int unsigned max_u(input int unsigned x, input int unsigned y);
    return (x > y) ? x : y;
  endfunction

  function automatic int unsigned frac_width(input int unsigned a_frac,
                                             input int unsigned b_frac);
    return max_u(a_frac, b_frac);
  endfunction

  // One guard integer bit on top of the wider operand makes the sum exact.
  function automatic int unsigned aligned_width(input int unsigned a_width,
                                                input int unsigned a_frac,
                                                input int unsigned b_width,
                                                input int unsigned b_frac);
    return max_u(a_width - a_frac, b_width - b_frac) + 1 + max_u(a_frac, b_frac);
  endfunction

  function automatic int unsigned drop_count(input int unsigned a_frac,
                                             input int unsigned b_frac,
                                             input int unsigned out_frac);
    int unsigned f;
    f = max_u(a_frac, b_frac);
    return (f > out_frac) ? f - out_frac : 0;
  endfunction

  function automatic int unsigned lift_count(input int unsigned a_frac,
                                             input int unsigned b_frac,
                                             input int unsigned out_frac);
    int unsigned f;
    f = max_u(a_frac, b_frac);
    return (out_frac > f) ? out_frac - f : 0;
  endfunction

  function automatic logic [63:0] sat_max(input int unsigned width);
    return (64'd1 << (width - 1)) - 64'd1;
  endfunction

  function automatic logic [63:0] sat_min(input int unsigned width);
    return 64'd1 << (width - 1);
  endfunction

endpackage

// File: rtl/fxp_lane_convert.sv
// One lane: align both operands, add or subtract exactly, requantise to the
// output format, then saturate or wrap and flag out-of-range results.
module fxp_lane_convert
  import fxp_pkg::*;
#(
  parameter int unsigned INPUT_A_WIDTH = 16,
  parameter int unsigned INPUT_A_FRAC  = 10,
  parameter int unsigned INPUT_B_WIDTH = 12,
  parameter int unsigned INPUT_B_FRAC  = 6,
  parameter int unsigned OUTPUT_WIDTH  = 12,
  parameter int unsigned OUTPUT_FRAC   = 8,
  parameter int unsigned ROUND         = 0,
  parameter int unsigned SAT           = 1
) (
  input  logic                     op_sub,
  input  logic [INPUT_A_WIDTH-1:0] a,
  input  logic [INPUT_B_WIDTH-1:0] b,
  output logic [OUTPUT_WIDTH-1:0]  res,
  output logic                     ovf
);

  localparam int unsigned F  = frac_width(INPUT_A_FRAC, INPUT_B_FRAC);
  localparam int unsigned W  = aligned_width(INPUT_A_WIDTH, INPUT_A_FRAC,
                                             INPUT_B_WIDTH, INPUT_B_FRAC);
  localparam int unsigned D  = drop_count(INPUT_A_FRAC, INPUT_B_FRAC, OUTPUT_FRAC);
  localparam int unsigned L  = lift_count(INPUT_A_FRAC, INPUT_B_FRAC, OUTPUT_FRAC);
  localparam int unsigned CW = W + 1 + L;
  localparam int unsigned EW = max_u(CW, OUTPUT_WIDTH + 1);
  localparam round_e RndMode = (ROUND != 0) ? RND_HALF_UP : RND_TRUNC;
  localparam logic [OUTPUT_WIDTH-1:0] SatHi = OUTPUT_WIDTH'(sat_max(OUTPUT_WIDTH));
  localparam logic [OUTPUT_WIDTH-1:0] SatLo = OUTPUT_WIDTH'(sat_min(OUTPUT_WIDTH));

  logic signed [W-1:0]  a_al, b_al, sum;
  logic signed [CW-1:0] conv;
  logic signed [EW-1:0] wide;
  logic [EW-OUTPUT_WIDTH:0] wide_hi;

  assign a_al = $signed({{(W - INPUT_A_WIDTH){a[INPUT_A_WIDTH-1]}}, a}) <<< (F - INPUT_A_FRAC);
  assign b_al = $signed({{(W - INPUT_B_WIDTH){b[INPUT_B_WIDTH-1]}}, b}) <<< (F - INPUT_B_FRAC);
  assign sum  = op_sub ? (a_al - b_al) : (a_al + b_al);

  if (D > 0) begin : g_drop
    // Bias is added one bit wider so rounding the most positive sum cannot wrap.
    localparam logic [W:0] Bias = (RndMode == RND_HALF_UP) ?
                                  ({{W{1'b0}}, 1'b1} << (D - 1)) : '0;
    logic signed [W:0] ext;
    assign ext  = $signed({sum[W-1], sum} + Bias);
    assign conv = ext >>> D;
  end else if (L > 0) begin : g_lift
    assign conv = {sum[W-1], sum, {L{1'b0}}};
  end else begin : g_keep
    assign conv = {sum[W-1], sum};
  end

  assign wide    = EW'(conv);
  assign wide_hi = wide[EW-1:OUTPUT_WIDTH-1];
  assign ovf     = ~((&wide_hi) | ~(|wide_hi));

  always_comb begin
    res = wide[OUTPUT_WIDTH-1:0];
    if (ovf && (SAT != 0)) begin
      res = wide[EW-1] ? SatLo : SatHi;
    end
  end

endmodule

// File: rtl/fxp_add_stream.sv
// Multi-lane fixed-point add/sub with valid/ready flow control. Compute sits in
// the first stage; the rest of the pipe is delay that stalls as a whole.
module fxp_add_stream
  import fxp_pkg::*;
#(
  parameter int unsigned LANES         = 4,
  parameter int unsigned INPUT_A_WIDTH = 16,
  parameter int unsigned INPUT_A_FRAC  = 10,
  parameter int unsigned INPUT_B_WIDTH = 12,
  parameter int unsigned INPUT_B_FRAC  = 6,
  parameter int unsigned OUTPUT_WIDTH  = 12,
  parameter int unsigned OUTPUT_FRAC   = 8,
  parameter int unsigned DELAY         = 3,
  parameter int unsigned ROUND         = 0,
  parameter int unsigned SAT           = 1
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic                             op_sub,
  input  logic [LANES*INPUT_A_WIDTH-1:0]   a_in,
  input  logic [LANES*INPUT_B_WIDTH-1:0]   b_in,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [LANES*OUTPUT_WIDTH-1:0]    out,
  output logic [LANES-1:0]                 ovf,
  output logic [LANES-1:0]                 ovf_sticky,
  input  logic                             clr_ovf
);

  localparam int unsigned OutBits = LANES * OUTPUT_WIDTH;

  logic [OutBits-1:0] res_d;
  logic [LANES-1:0]   ovf_d;
  logic               valid_q [DELAY];
  logic [OutBits-1:0] res_q   [DELAY];
  logic [LANES-1:0]   ovf_q   [DELAY];
  logic [LANES-1:0]   sticky_d, sticky_q;
  logic               advance, out_fire;

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    fxp_lane_convert #(
      .INPUT_A_WIDTH(INPUT_A_WIDTH),
      .INPUT_A_FRAC (INPUT_A_FRAC),
      .INPUT_B_WIDTH(INPUT_B_WIDTH),
      .INPUT_B_FRAC (INPUT_B_FRAC),
      .OUTPUT_WIDTH (OUTPUT_WIDTH),
      .OUTPUT_FRAC  (OUTPUT_FRAC),
      .ROUND        (ROUND),
      .SAT          (SAT)
    ) u_conv (
      .op_sub(op_sub),
      .a     (a_in[i*INPUT_A_WIDTH +: INPUT_A_WIDTH]),
      .b     (b_in[i*INPUT_B_WIDTH +: INPUT_B_WIDTH]),
      .res   (res_d[i*OUTPUT_WIDTH +: OUTPUT_WIDTH]),
      .ovf   (ovf_d[i])
    );
  end

  assign out_valid  = valid_q[DELAY-1];
  assign out        = res_q[DELAY-1];
  assign ovf        = ovf_q[DELAY-1];
  assign advance    = out_ready | ~out_valid;
  assign in_ready   = advance;
  assign out_fire   = out_valid & out_ready;
  assign ovf_sticky = sticky_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned s = 0; s < DELAY; s++) begin
        valid_q[s] <= 1'b0;
        res_q[s]   <= '0;
        ovf_q[s]   <= '0;
      end
    end else if (advance) begin
      valid_q[0] <= in_valid;
      res_q[0]   <= res_d;
      ovf_q[0]   <= ovf_d;
      for (int unsigned s = 1; s < DELAY; s++) begin
        valid_q[s] <= valid_q[s-1];
        res_q[s]   <= res_q[s-1];
        ovf_q[s]   <= ovf_q[s-1];
      end
    end
  end

  // A clear in the same cycle as a flagged handshake keeps the new flag.
  always_comb begin
    sticky_d = clr_ovf ? '0 : sticky_q;
    if (out_fire) begin
      sticky_d = sticky_d | ovf;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sticky_q <= '0;
    end else begin
      sticky_q <= sticky_d;
    end
  end

endmodule
